// File: rtl/mlp_seq_pkg.sv
// Shared opcodes, FSM state encoding, config select codes and config defaults
// for the MLP command sequencer.
package mlp_seq_pkg;

  localparam logic [7:0] OP_LOAD_W = 8'h01;
  localparam logic [7:0] OP_LOAD_A = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_CFG    = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WRST  = 4'd1,
    S_WLOAD = 4'd2,
    S_ALO   = 4'd3,
    S_AHI   = 4'd4,
    S_RUN   = 4'd5,
    S_WAIT  = 4'd6,
    S_RESP  = 4'd7,
    S_CFG   = 4'd8
  } state_e;

  localparam logic [7:0] SEL_GAIN  = 8'd0;
  localparam logic [7:0] SEL_BIAS  = 8'd1;
  localparam logic [7:0] SEL_SHIFT = 8'd2;
  localparam logic [7:0] SEL_INV   = 8'd3;
  localparam logic [7:0] SEL_ZP    = 8'd4;

  // Q8 fixed point: 256 is 1.0, a shift of 8 undoes the Q8 scaling.
  localparam logic [15:0] DEF_GAIN  = 16'd256;
  localparam logic [31:0] DEF_BIAS  = 32'd0;
  localparam logic [4:0]  DEF_SHIFT = 5'd8;
  localparam logic [15:0] DEF_INV   = 16'd256;
  localparam logic [7:0]  DEF_ZP    = 8'd0;

endpackage

// File: rtl/mlp_seq_cfg_regs.sv
// Activation-pipeline config registers with a 1-select + 4-data-byte assembler.
// Only present when MLP_SEQ_CFG_EN is defined.
`ifdef MLP_SEQ_CFG_EN
module mlp_seq_cfg_regs
  import mlp_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_stb,
  input  logic [2:0]  byte_idx,
  input  logic [7:0]  byte_data,
  output logic        sel_bad,
  output logic [15:0] norm_gain,
  output logic [31:0] norm_bias,
  output logic [4:0]  norm_shift,
  output logic [15:0] q_inv_scale,
  output logic [7:0]  q_zero_point
);

  logic [7:0]  sel_q, sel_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] word;
  logic [15:0] gain_q, gain_d, inv_q, inv_d;
  logic [31:0] bias_q, bias_d;
  logic [4:0]  shift_q, shift_d;
  logic [7:0]  zp_q, zp_d;

  assign sel_bad = byte_stb && (byte_idx == 3'd0) && (byte_data > SEL_ZP);

  always_comb begin
    sel_d   = sel_q;
    asm_d   = asm_q;
    gain_d  = gain_q;
    bias_d  = bias_q;
    shift_d = shift_q;
    inv_d   = inv_q;
    zp_d    = zp_q;
    word    = {byte_data, asm_q};
    if (byte_stb) begin
      case (byte_idx)
        3'd0: sel_d = byte_data;
        3'd1: asm_d[7:0] = byte_data;
        3'd2: asm_d[15:8] = byte_data;
        3'd3: asm_d[23:16] = byte_data;
        3'd4: begin
          // An invalid select falls through every arm, discarding the word.
          case (sel_q)
            SEL_GAIN:  gain_d  = word[15:0];
            SEL_BIAS:  bias_d  = word;
            SEL_SHIFT: shift_d = word[4:0];
            SEL_INV:   inv_d   = word[15:0];
            SEL_ZP:    zp_d    = word[7:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      asm_q   <= '0;
      gain_q  <= DEF_GAIN;
      bias_q  <= DEF_BIAS;
      shift_q <= DEF_SHIFT;
      inv_q   <= DEF_INV;
      zp_q    <= DEF_ZP;
    end else begin
      sel_q   <= sel_d;
      asm_q   <= asm_d;
      gain_q  <= gain_d;
      bias_q  <= bias_d;
      shift_q <= shift_d;
      inv_q   <= inv_d;
      zp_q    <= zp_d;
    end
  end

  assign norm_gain    = gain_q;
  assign norm_bias    = bias_q;
  assign norm_shift   = shift_q;
  assign q_inv_scale  = inv_q;
  assign q_zero_point = zp_q;

endmodule
`endif

// File: rtl/mlp_sequencer.sv
// Byte-command sequencer between the UART and the MLP: loads weights/activation,
// runs the MLP with a timeout and returns the accumulator. CFG opcode: MLP_SEQ_CFG_EN.
module mlp_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int          ARRAY_N     = 2,
  parameter logic [3:0]  DONE_STATE  = 4'd6,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // Both handshakes: a transfer happens on a cycle where valid && ready.
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic        bad_op,
  output logic        mlp_wf_push_col0,
  output logic        mlp_wf_push_col1,
  output logic [7:0]  mlp_wf_data_in,
  output logic        mlp_wf_reset,
  output logic        mlp_init_act_valid,
  output logic [15:0] mlp_init_act_data,
  output logic        mlp_start_mlp,
  output logic        mlp_weights_ready,
  output logic [15:0] mlp_norm_gain,
  output logic [31:0] mlp_norm_bias,
  output logic [4:0]  mlp_norm_shift,
  output logic [15:0] mlp_q_inv_scale,
  output logic [7:0]  mlp_q_zero_point,
  input  logic [3:0]  mlp_state_in,
  input  logic [31:0] mlp_acc0_in,
  output logic [3:0]  dbg_state
);

  localparam int CNT_W = $clog2(2 * ARRAY_N + 5);
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               wready_q, wready_d, bad_op_q, bad_op_d;
  logic               wf_reset_q, wf_reset_d, push0_q, push0_d, push1_q, push1_d;
  logic [7:0]         wf_data_q, wf_data_d, act_lo_q, act_lo_d;
  logic               act_valid_q, act_valid_d, start_q, start_d;
  logic [15:0]        act_data_q, act_data_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic               accept;

`ifdef MLP_SEQ_CFG_EN
  logic cfg_sel_bad;
  mlp_seq_cfg_regs u_cfg (
    .clk          (clk),
    .rst          (rst),
    .byte_stb     (accept && (state_q == S_CFG)),
    .byte_idx     (cnt_q[2:0]),
    .byte_data    (cmd_data),
    .sel_bad      (cfg_sel_bad),
    .norm_gain    (mlp_norm_gain),
    .norm_bias    (mlp_norm_bias),
    .norm_shift   (mlp_norm_shift),
    .q_inv_scale  (mlp_q_inv_scale),
    .q_zero_point (mlp_q_zero_point)
  );
`else
  assign mlp_norm_gain    = DEF_GAIN;
  assign mlp_norm_bias    = DEF_BIAS;
  assign mlp_norm_shift   = DEF_SHIFT;
  assign mlp_q_inv_scale  = DEF_INV;
  assign mlp_q_zero_point = DEF_ZP;
`endif

  always_comb begin
    cmd_ready = (state_q == S_IDLE) || (state_q == S_WLOAD) || (state_q == S_ALO) ||
                (state_q == S_AHI) || (state_q == S_CFG);
  end
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    wready_d    = wready_q;
    bad_op_d    = bad_op_q;
    wf_reset_d  = 1'b0;
    push0_d     = 1'b0;
    push1_d     = 1'b0;
    wf_data_d   = wf_data_q;
    act_valid_d = 1'b0;
    act_data_d  = act_data_q;
    act_lo_d    = act_lo_q;
    start_d     = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_data)
            OP_LOAD_W: state_d = S_WRST;
            OP_LOAD_A: state_d = S_ALO;
            OP_RUN:    state_d = S_RUN;
`ifdef MLP_SEQ_CFG_EN
            OP_CFG: begin
              state_d = S_CFG;
              cnt_d   = '0;
            end
`endif
            default:   bad_op_d = 1'b1;
          endcase
        end
      end
      S_WRST: begin
        wf_reset_d = 1'b1;
        wready_d   = 1'b0;
        cnt_d      = '0;
        state_d    = S_WLOAD;
      end
      S_WLOAD: begin
        if (accept) begin
          wf_data_d = cmd_data;
          if (cnt_q < CNT_W'(ARRAY_N)) push0_d = 1'b1;
          else                         push1_d = 1'b1;
          if (cnt_q == CNT_W'(2 * ARRAY_N - 1)) begin
            wready_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ALO: begin
        if (accept) begin
          act_lo_d = cmd_data;
          state_d  = S_AHI;
        end
      end
      S_AHI: begin
        if (accept) begin
          act_data_d  = {cmd_data, act_lo_q};
          act_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RUN: begin
        if (!wready_q) begin
          res_err_d  = 1'b1;
          res_data_d = '0;
          state_d    = S_RESP;
        end else begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // tmo_q == 0 is the cycle the start pulse is visible; DONE there is stale.
        if ((tmo_q != '0) && (mlp_state_in == DONE_STATE)) begin
          res_data_d = mlp_acc0_in;
          res_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      S_CFG: begin
        if (accept) begin
`ifdef MLP_SEQ_CFG_EN
          if (cfg_sel_bad) bad_op_d = 1'b1;
`endif
          if (cnt_q == CNT_W'(4)) state_d = S_IDLE;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      wready_q    <= 1'b0;
      bad_op_q    <= 1'b0;
      wf_reset_q  <= 1'b0;
      push0_q     <= 1'b0;
      push1_q     <= 1'b0;
      wf_data_q   <= '0;
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
      act_lo_q    <= '0;
      start_q     <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      wready_q    <= wready_d;
      bad_op_q    <= bad_op_d;
      wf_reset_q  <= wf_reset_d;
      push0_q     <= push0_d;
      push1_q     <= push1_d;
      wf_data_q   <= wf_data_d;
      act_valid_q <= act_valid_d;
      act_data_q  <= act_data_d;
      act_lo_q    <= act_lo_d;
      start_q     <= start_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_valid          = (state_q == S_RESP);
  assign res_data           = res_data_q;
  assign res_err            = res_err_q;
  assign busy               = (state_q != S_IDLE);
  assign bad_op             = bad_op_q;
  assign mlp_wf_push_col0   = push0_q;
  assign mlp_wf_push_col1   = push1_q;
  assign mlp_wf_data_in     = wf_data_q;
  assign mlp_wf_reset       = wf_reset_q;
  assign mlp_init_act_valid = act_valid_q;
  assign mlp_init_act_data  = act_data_q;
  assign mlp_start_mlp      = start_q;
  assign mlp_weights_ready  = wready_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: table of per-cycle vectors for LOAD_W/LOAD_A,
// plus hand-written RUN, timeout, bad opcode, config and mid-load reset sequences.
module tb_mlp_sequencer;

  localparam int TIMEOUT_CYC = 1024;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy, bad_op;
  logic [7:0]  cmd_data;
  logic [31:0] res_data;
  logic        push0, push1, wf_reset, act_valid, start, wready;
  logic [7:0]  wf_data, zp;
  logic [15:0] act_data, gain, inv;
  logic [31:0] bias;
  logic [4:0]  shift;
  logic [3:0]  mlp_state, dbg_state;
  logic [31:0] acc0;

  int total = 0;
  int passed = 0;

  mlp_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_data           (cmd_data),
    .cmd_ready          (cmd_ready),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_err            (res_err),
    .busy               (busy),
    .bad_op             (bad_op),
    .mlp_wf_push_col0   (push0),
    .mlp_wf_push_col1   (push1),
    .mlp_wf_data_in     (wf_data),
    .mlp_wf_reset       (wf_reset),
    .mlp_init_act_valid (act_valid),
    .mlp_init_act_data  (act_data),
    .mlp_start_mlp      (start),
    .mlp_weights_ready  (wready),
    .mlp_norm_gain      (gain),
    .mlp_norm_bias      (bias),
    .mlp_norm_shift     (shift),
    .mlp_q_inv_scale    (inv),
    .mlp_q_zero_point   (zp),
    .mlp_state_in       (mlp_state),
    .mlp_acc0_in        (acc0),
    .dbg_state          (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  typedef struct packed {
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        bsy;
    logic        wrst;
    logic        p0;
    logic        p1;
    logic [7:0]  wdat;
    logic        av;
    logic [15:0] adat;
    logic        wr;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic rdy,
                              input logic bsy, input logic wrst, input logic p0,
                              input logic p1, input logic [7:0] wdat, input logic av,
                              input logic [15:0] adat, input logic wr);
    vec_t v;
    v.vld = vld; v.dat = dat; v.rdy = rdy; v.bsy = bsy; v.wrst = wrst;
    v.p0 = p0; v.p1 = p1; v.wdat = wdat; v.av = av; v.adat = adat; v.wr = wr;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) bound_fail("cmd_ready_wait");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int max_cyc, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    if (!res_valid) bound_fail("res_valid_wait");
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gain"},      {16'd0, gain},  32'd256);
    check({tag, "_bias"},      bias,           32'd0);
    check({tag, "_shift"},     {27'd0, shift}, 32'd8);
    check({tag, "_inv"},       {16'd0, inv},   32'd256);
    check({tag, "_zp"},        {24'd0, zp},    32'd0);
    check({tag, "_busy"},      {31'd0, busy},  32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_bad_op"},    {31'd0, bad_op}, 32'd0);
    check({tag, "_wready"},    {31'd0, wready}, 32'd0);
    check({tag, "_strobes"},   {27'd0, push0, push1, wf_reset, act_valid, start}, 32'd0);
    check({tag, "_data"},      {wf_data, act_data, 8'd0}, 32'd0);
    check({tag, "_res"},       {res_err, res_data[30:0]}, 32'd0);
  endtask

  // Scoreboard-style run check: expected result computed here from the stimulus.
  task automatic run_expect(input string name, input logic exp_err, input logic [31:0] exp_data);
    check({name, "_err"},  {31'd0, res_err}, {31'd0, exp_err});
    check({name, "_data"}, res_data, exp_data);
  endtask

  initial begin
    int cyc;
    bit stable;
    logic [30:0] obs, expv;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    res_ready = 1'b0;
    mlp_state = '0;
    acc0 = '0;

    vt[0]  = mk(1, 8'h01, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    vt[1]  = mk(1, 8'h11, 0, 1, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    vt[2]  = mk(1, 8'h11, 1, 1, 1, 0, 0, 8'h00, 0, 16'h0000, 0);
    vt[3]  = mk(1, 8'h22, 1, 1, 0, 1, 0, 8'h11, 0, 16'h0000, 0);
    vt[4]  = mk(0, 8'h00, 1, 1, 0, 1, 0, 8'h22, 0, 16'h0000, 0);
    vt[5]  = mk(1, 8'h33, 1, 1, 0, 0, 0, 8'h22, 0, 16'h0000, 0);
    vt[6]  = mk(1, 8'h44, 1, 1, 0, 0, 1, 8'h33, 0, 16'h0000, 0);
    vt[7]  = mk(1, 8'h02, 1, 0, 0, 0, 1, 8'h44, 0, 16'h0000, 1);
    vt[8]  = mk(1, 8'h34, 1, 1, 0, 0, 0, 8'h44, 0, 16'h0000, 1);
    vt[9]  = mk(1, 8'h12, 1, 1, 0, 0, 0, 8'h44, 0, 16'h0000, 1);
    vt[10] = mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h44, 1, 16'h1234, 1);
    vt[11] = mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h44, 0, 16'h1234, 1);

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;
    tick();

    // RUN with no weights loaded: immediate error result
    send_byte(8'h03);
    wait_res(5, cyc);
    run_expect("run_noweights", 1'b1, 32'd0);
    take_res();
    check("noweights_release", {30'd0, res_valid, busy}, 32'd0);

    // LOAD_W then LOAD_A, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      cmd_valid = vt[i].vld;
      cmd_data  = vt[i].dat;
      obs  = {cmd_ready, busy, wf_reset, push0, push1, wf_data, act_valid, act_data, wready};
      expv = {vt[i].rdy, vt[i].bsy, vt[i].wrst, vt[i].p0, vt[i].p1, vt[i].wdat,
              vt[i].av, vt[i].adat, vt[i].wr};
      check($sformatf("vec[%0d]", i), {1'b0, obs}, {1'b0, expv});
      tick();
    end
    cmd_valid = 1'b0;

    // RUN, DONE after ~20 cycles, acc0 = -5, result held while res_ready low
    mlp_state = 4'd0;
    acc0 = -32'sd5;
    send_byte(8'h03);
    check("start_before", {31'd0, start}, 32'd0);
    tick();
    check("start_pulse", {31'd0, start}, 32'd1);
    tick();
    check("start_after", {31'd0, start}, 32'd0);
    repeat (18) tick();
    mlp_state = 4'd6;
    wait_res(10, cyc);
    run_expect("run_done", 1'b0, 32'hFFFF_FFFB);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFB || res_err !== 1'b0) stable = 1'b0;
    end
    check("resp_hold", {31'd0, stable}, 32'd1);
    take_res();
    check("resp_to_idle", {27'd0, res_valid, dbg_state}, 32'd0);
    check("wready_after_run", {31'd0, wready}, 32'd1);

    // DONE already asserted at start must be ignored in the first wait cycle
    mlp_state = 4'd6;
    acc0 = 32'd111;
    send_byte(8'h03);
    tick();
    tick();
    acc0 = 32'd222;
    wait_res(5, cyc);
    run_expect("stale_done", 1'b0, 32'd222);
    take_res();

    // MLP never finishes: timeout after TIMEOUT_CYC wait cycles
    mlp_state = 4'd0;
    send_byte(8'h03);
    tick();
    wait_res(TIMEOUT_CYC + 100, cyc);
    check("timeout_cycles", cyc, TIMEOUT_CYC);
    run_expect("timeout", 1'b1, 32'd0);
    take_res();
    check("wready_after_timeout", {31'd0, wready}, 32'd1);

`ifdef MLP_SEQ_CFG_EN
    send_byte(8'h04); send_byte(8'h02); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("cfg_shift", {27'd0, shift}, 32'd5);
    check("cfg_gain_kept", {16'd0, gain}, 32'd256);
    check("cfg_bad_op_clear", {30'd0, bad_op, busy}, 32'd0);
    send_byte(8'h04); send_byte(8'h01); send_byte(8'h78);
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("cfg_bias", bias, 32'h1234_5678);
    send_byte(8'h04); send_byte(8'h09); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("cfg_bad_sel", {30'd0, bad_op, busy}, 32'd2);
    check("cfg_bad_sel_keep", {27'd0, shift}, 32'd5);
`else
    send_byte(8'h04);
    check("op04_bad", {30'd0, bad_op, busy}, 32'd2);
    check("op04_cfg_const", {27'd0, shift}, 32'd8);
`endif

    // Unknown opcode: bad_op sticky across later good commands
    send_byte(8'h7F);
    check("op7f_bad", {30'd0, bad_op, busy}, 32'd2);
    send_byte(8'h02);
    send_byte(8'h78);
    send_byte(8'h56);
    check("act_5678", {15'd0, act_valid, act_data}, {15'd0, 1'b1, 16'h5678});
    check("bad_op_sticky", {31'd0, bad_op}, 32'd1);

    // Reset in the middle of a weight load
    send_byte(8'h01);
    send_byte(8'hAA);
    cmd_valid = 1'b1;
    cmd_data  = 8'hBB;
    check("midload_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midload");
    cmd_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h03);
    wait_res(5, cyc);
    run_expect("run_after_rst", 1'b1, 32'd0);
    take_res();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
